// File: rtl/spi_device_pkg.sv
// Shared definitions for the SPI responder: frame width, bit counter and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_device_pkg;

  localparam int unsigned SpiByteW = 8;
  localparam int unsigned BitCntW  = $clog2(SpiByteW);

  // Counter value at the last bit of a byte; the next rising strobe completes it.
  localparam logic [BitCntW-1:0] BitCntMax = BitCntW'(SpiByteW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_device_sync.sv
// Two-flop synchroniser for one asynchronous input, with a selectable reset level.
// Latency: 2 clk_i cycles from pin to q_o.
// Backpressure: none.
//
// Ports: clk_i/rst_ni clock and async active-low reset; d_i asynchronous input;
//        q_o synchronised output.
module spi_device_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_device.sv
// SPI mode-0 responder, MSB first, 8-bit frames, oversampled on clk_sys_i.
// Latency: MOSI sampled 3 cycles after pin SCK rise, MISO moves 4 cycles after SCK/CS_n fall.
// Backpressure: TX port is ready/valid with a one-byte buffer; RX has none (pulse only).
//
// Ports: clk_sys_i/rst_sys_ni clock and async active-low reset;
//        spi_sck_i, spi_cs_ni, spi_mosi_i asynchronous host lines; spi_miso_o registered data;
//        rx_data_o/rx_valid_o received byte and its one-cycle strobe;
//        tx_data_i/tx_valid_i/tx_ready_o TX buffer handshake; tx_underrun_o idle-byte load pulse.
module spi_device
  import spi_device_pkg::*;
#(
  parameter int unsigned         IdleTimeout = 256,
  parameter logic [SpiByteW-1:0] TxIdleByte  = 8'hFF
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_ni,
  input  logic                spi_sck_i,
  input  logic                spi_cs_ni,
  input  logic                spi_mosi_i,
  output logic                spi_miso_o,
  output logic [SpiByteW-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic [SpiByteW-1:0] tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic                tx_underrun_o
);

  localparam int unsigned           IdleCntW = $clog2(IdleTimeout + 1);
  localparam logic [IdleCntW-1:0]   IdleMax  = IdleCntW'(IdleTimeout);
  localparam logic [IdleCntW-1:0]   IdleLast = IdleCntW'(IdleTimeout - 1);

  logic sck_sync, cs_sync, mosi_sync;

  spi_device_sync #(.ResetVal(1'b0)) u_sync_sck (
    .clk_i(clk_sys_i), .rst_ni(rst_sys_ni), .d_i(spi_sck_i), .q_o(sck_sync)
  );
  spi_device_sync #(.ResetVal(1'b1)) u_sync_cs (
    .clk_i(clk_sys_i), .rst_ni(rst_sys_ni), .d_i(spi_cs_ni), .q_o(cs_sync)
  );
  spi_device_sync #(.ResetVal(1'b0)) u_sync_mosi (
    .clk_i(clk_sys_i), .rst_ni(rst_sys_ni), .d_i(spi_mosi_i), .q_o(mosi_sync)
  );

  state_e               state_q, state_d;
  logic                 sck_q, cs_q;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SpiByteW-1:0]  rx_shift_q, rx_shift_d;
  logic [SpiByteW-1:0]  tx_shift_q, tx_shift_d;
  logic [SpiByteW-1:0]  rx_data_q, rx_data_d;
  logic [SpiByteW-1:0]  buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic                 load_pend_q, load_pend_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 underrun_q, underrun_d;
  logic                 miso_q, miso_d;
  logic [IdleCntW-1:0]  idle_cnt_q, idle_cnt_d;

  logic sck_rise, sck_fall, cs_fall, cs_rise, activity, idle_expire, frame_load, tx_load;

  assign sck_rise    = sck_sync & ~sck_q;
  assign sck_fall    = ~sck_sync & sck_q;
  assign cs_fall     = ~cs_sync & cs_q;
  assign cs_rise     = cs_sync & ~cs_q;
  assign activity    = sck_rise | sck_fall | cs_fall | cs_rise;
  // Fires only on the step into saturation, so once per idle period.
  assign idle_expire = ~activity && (idle_cnt_q == IdleLast);
  assign frame_load  = cs_fall | idle_expire;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    load_pend_d = load_pend_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    rx_done_d   = 1'b0;
    underrun_d  = 1'b0;
    tx_load     = 1'b0;
    // rx_data/rx_valid trail rx_done by a cycle; MISO trails tx_shift by a cycle.
    rx_valid_d  = rx_done_q;
    rx_data_d   = rx_done_q ? rx_shift_q : rx_data_q;
    miso_d      = tx_shift_q[SpiByteW-1];

    if (activity) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleMax) begin
      idle_cnt_d = idle_cnt_q + IdleCntW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    if (frame_load) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      load_pend_d = 1'b0;
      tx_load     = 1'b1;
    end else if (cs_rise) begin
      // Deselect mid-byte: drop partial RX bits and the rest of the TX byte.
      state_d     = IDLE;
      bit_cnt_d   = '0;
      load_pend_d = 1'b0;
    end else if (sck_rise && !cs_sync) begin
      state_d    = SHIFT;
      rx_shift_d = {rx_shift_q[SpiByteW-2:0], mosi_sync};
      bit_cnt_d  = bit_cnt_q + BitCntW'(1);
      if (bit_cnt_q == BitCntMax) begin
        rx_done_d   = 1'b1;
        load_pend_d = 1'b1;  // next falling edge loads the following TX byte
      end
    end else if (sck_fall && !cs_sync && (state_q == SHIFT)) begin
      if (load_pend_q) begin
        load_pend_d = 1'b0;
        tx_load     = 1'b1;
      end else begin
        tx_shift_d = {tx_shift_q[SpiByteW-2:0], 1'b0};
      end
    end

    if (tx_load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = TxIdleByte;
        underrun_d = 1'b1;
      end
    end

    // Only accepted while empty, so it can never collide with a consume.
    if (tx_valid_i && !buf_full_q) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q     <= IDLE;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= TxIdleByte;
      rx_data_q   <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      load_pend_q <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= TxIdleByte[SpiByteW-1];
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_sync;
      cs_q        <= cs_sync;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      load_pend_q <= load_pend_d;
      rx_done_q   <= rx_done_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = ~buf_full_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_device.sv
// Directed bench for spi_device acting as an SPI mode-0 host at SCK = clk/8.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_device;

  logic       clk_sys_i  = 1'b0;
  logic       rst_sys_ni = 1'b1;
  logic       spi_sck_i  = 1'b0;
  logic       spi_cs_ni  = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [7:0] tx_data_i  = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic       tx_underrun_o;

  spi_device dut (
    .clk_sys_i    (clk_sys_i),
    .rst_sys_ni   (rst_sys_ni),
    .spi_sck_i    (spi_sck_i),
    .spi_cs_ni    (spi_cs_ni),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_underrun_o(tx_underrun_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int         n_cmp    = 0;
  int         n_bad    = 0;
  int         rx_cnt   = 0;
  int         urun_cnt = 0;
  logic [7:0] rx_q[$];

  // Count strobe cycles on the falling clock edge, away from the DUT's active edge.
  always @(negedge clk_sys_i) begin
    if (rx_valid_o) begin
      rx_cnt++;
      rx_q.push_back(rx_data_o);
    end
    if (tx_underrun_o) urun_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
  endtask

  // Host side: MOSI set at the falling edge, MISO sampled just before the rising edge.
  task automatic spi_bits(input logic [7:0] d, input int nb, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi_mosi_i = d[7-i];
      tick(4);
      got[7-i]  = spi_miso_o;
      spi_sck_i = 1'b1;
      tick(4);
      spi_sck_i = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] g;
    logic [7:0] g2;
    int         r0;
    int         u0;
    int         q0;

    #2 rst_sys_ni = 1'b0;
    tick(3);
    check("rst_miso",     spi_miso_o,    32'h1);
    check("rst_rx_data",  rx_data_o,     32'h0);
    check("rst_rx_valid", rx_valid_o,    32'h0);
    check("rst_tx_ready", tx_ready_o,    32'h1);
    check("rst_underrun", tx_underrun_o, 32'h0);
    rst_sys_ni = 1'b1;
    tick(2);

    // Buffered A5 returned while 3C is received.
    push(8'hA5);
    check("t1_ready_full", tx_ready_o, 32'h0);
    r0 = rx_cnt;
    spi_cs_ni = 1'b0;
    tick(8);
    spi_bits(8'h3C, 8, g);
    spi_cs_ni = 1'b1;
    tick(8);
    check("t1_host_rx",  g,             32'hA5);
    check("t1_rx_count", rx_cnt - r0,   32'd1);
    check("t1_rx_data",  rx_data_o,     32'h3C);
    check("t1_ready",    tx_ready_o,    32'h1);

    // Empty buffer, two back-to-back bytes.
    r0 = rx_cnt; u0 = urun_cnt; q0 = rx_q.size();
    spi_cs_ni = 1'b0;
    tick(8);
    spi_bits(8'h01, 8, g);
    spi_bits(8'h80, 8, g2);
    spi_cs_ni = 1'b1;
    tick(8);
    check("t2_host_rx0", g,                32'hFF);
    check("t2_host_rx1", g2,               32'hFF);
    check("t2_underrun", urun_cnt - u0,    32'd2);
    check("t2_rx_count", rx_cnt - r0,      32'd2);
    check("t2_rx_byte0", rx_q[q0],         32'h01);
    check("t2_rx_byte1", rx_q[q0+1],       32'h80);

    // CS_n held low: partial byte abandoned by the idle timeout.
    r0 = rx_cnt;
    spi_cs_ni = 1'b0;
    tick(8);
    spi_bits(8'hA0, 3, g);
    tick(300);
    spi_bits(8'h5A, 8, g);
    spi_cs_ni = 1'b1;
    tick(8);
    check("t3_rx_count", rx_cnt - r0, 32'd1);
    check("t3_rx_data",  rx_data_o,   32'h5A);

    // CS_n raised after 5 bits, then a full frame with a buffered reply.
    r0 = rx_cnt;
    spi_cs_ni = 1'b0;
    tick(8);
    spi_bits(8'hFF, 5, g);
    spi_cs_ni = 1'b1;
    tick(8);
    check("t4_partial_none", rx_cnt - r0, 32'd0);
    push(8'h96);
    spi_cs_ni = 1'b0;
    tick(8);
    spi_bits(8'hC3, 8, g);
    spi_cs_ni = 1'b1;
    tick(8);
    check("t4_host_rx",  g,           32'h96);
    check("t4_rx_count", rx_cnt - r0, 32'd1);
    check("t4_rx_data",  rx_data_o,   32'hC3);

    // Handshake lands on the same cycle as the CS_n-fall load from an empty buffer.
    u0 = urun_cnt;
    spi_cs_ni = 1'b0;
    tick(2);
    tx_data_i  = 8'h77;
    tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    tick(3);
    check("t5_underrun",   urun_cnt - u0, 32'd1);
    check("t5_ready_full", tx_ready_o,    32'h0);
    tick(2);
    spi_bits(8'h11, 8, g);
    spi_bits(8'h22, 8, g2);
    spi_cs_ni = 1'b1;
    tick(8);
    check("t5_host_rx0", g,  32'hFF);
    check("t5_host_rx1", g2, 32'h77);

    // Reset mid-byte with MISO low, buffer full and a non-zero rx_data.
    push(8'h0F);
    spi_cs_ni = 1'b0;
    tick(8);
    push(8'h3A);
    spi_bits(8'hFF, 4, g);
    rst_sys_ni = 1'b0;
    #1;
    check("t6_rst_miso",     spi_miso_o,    32'h1);
    check("t6_rst_rx_data",  rx_data_o,     32'h0);
    check("t6_rst_rx_valid", rx_valid_o,    32'h0);
    check("t6_rst_tx_ready", tx_ready_o,    32'h1);
    check("t6_rst_underrun", tx_underrun_o, 32'h0);
    spi_cs_ni = 1'b1;
    tick(2);
    rst_sys_ni = 1'b1;
    tick(4);
    push(8'hE7);
    r0 = rx_cnt;
    spi_cs_ni = 1'b0;
    tick(8);
    spi_bits(8'h81, 8, g);
    spi_cs_ni = 1'b1;
    tick(8);
    check("t6_host_rx",  g,           32'hE7);
    check("t6_rx_count", rx_cnt - r0, 32'd1);
    check("t6_rx_data",  rx_data_o,   32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
